// File: rtl/pp_combine_108.sv
// Recombines the six 45-bit partial products of the 54x54 multiplier into a 108-bit product.
// Two registered adder stages; the whole pipe freezes when the output is held by the consumer.
module pp_combine_108 #(
    parameter int PP_W  = 45,
    parameter int OUT_W = 108,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [PP_W-1:0]  pp_0,
    input  logic [PP_W-1:0]  pp_1,
    input  logic [PP_W-1:0]  pp_2,
    input  logic [PP_W-1:0]  pp_3,
    input  logic [PP_W-1:0]  pp_4,
    input  logic [PP_W-1:0]  pp_5,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] prod,
    output logic [TAG_W-1:0] out_tag
);
    // Each half-sum spans three 18-bit-spaced partials: PP_W + 36 bits.
    localparam int S1_W    = PP_W + 36;
    localparam int B_STEP  = 18;
    localparam int HI_SHIFT = 27;

    logic [PP_W-1:0]  w_pp   [6];
    logic [S1_W-1:0]  w_term [6];
    logic [S1_W-1:0]  w_lo;
    logic [S1_W-1:0]  w_hi;
    logic [OUT_W-1:0] w_prod;
    logic             w_stall;
    logic             w_advance;

    logic             r_v1;
    logic [TAG_W-1:0] r_tag1;
    logic [S1_W-1:0]  r_lo;
    logic [S1_W-1:0]  r_hi;
    logic             r_out_valid;
    logic [OUT_W-1:0] r_prod;
    logic [TAG_W-1:0] r_out_tag;

    assign w_pp[0] = pp_0;
    assign w_pp[1] = pp_1;
    assign w_pp[2] = pp_2;
    assign w_pp[3] = pp_3;
    assign w_pp[4] = pp_4;
    assign w_pp[5] = pp_5;

    // pp_k sits at 18*(k%3) inside its half; the a[53:27] half is offset later.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_term
            assign w_term[gi] = S1_W'(w_pp[gi]) << (B_STEP * (gi % 3));
        end
    endgenerate

    assign w_lo = w_term[0] + w_term[1] + w_term[2];
    assign w_hi = w_term[3] + w_term[4] + w_term[5];

    assign w_prod = OUT_W'(r_lo) + (OUT_W'(r_hi) << HI_SHIFT);

    // No bubble collapse: a held output freezes both stages.
    assign w_stall   = r_out_valid & ~out_ready;
    assign w_advance = ~w_stall;
    assign in_ready  = w_advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1        <= 1'b0;
            r_tag1      <= '0;
            r_lo        <= '0;
            r_hi        <= '0;
            r_out_valid <= 1'b0;
            r_prod      <= '0;
            r_out_tag   <= '0;
        end else if (w_advance) begin
            r_v1        <= in_valid;
            r_tag1      <= in_tag;
            r_lo        <= w_lo;
            r_hi        <= w_hi;
            r_out_valid <= r_v1;
            r_prod      <= w_prod;
            r_out_tag   <= r_tag1;
        end
    end

    assign out_valid = r_out_valid;
    assign prod      = r_prod;
    assign out_tag   = r_out_tag;

endmodule

// File: doc/pp_combine_108.md
Name: pp_combine_108

Overview:
- Downstream stage of the 54x54 DSP partial-product multiplier.
- Takes the six 45-bit partial products and recombines them into the full 108-bit unsigned product:
  - res_0..res_2 = a[26:0] * b slices
  - res_3..res_5 = a[53:27] * b slices
  - b slices are 18 bits each.
- Two-stage registered adder tree with valid/ready flow control and a passthrough tag, so the result can feed the mantissa-normalise stage.

Parameters:
- PP_W, 45, width of each partial product.
- OUT_W, 108, width of the recombined product; fixed at 2*54.
- TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports:
- clk  input  1  single clock for all state.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  partial products and tag are valid this cycle.
- in_ready  output  1  stage can accept an input this cycle.
- in_tag  input  TAG_W  sideband tag, returned unchanged with the result.
- pp_0 .. pp_5  input  PP_W each  partial products res_0..res_5 from the multiplier.
- out_valid  output  1  prod and out_tag are valid.
- out_ready  input  1  consumer accepts the result this cycle.
- prod  output  OUT_W  recombined product.
- out_tag  output  TAG_W  tag of the operation in prod.

Behaviour:
- Weights (bit shifts):
  - pp_0 at 0, pp_1 at 18, pp_2 at 36
  - pp_3 at 27, pp_4 at 45, pp_5 at 63
- Stage 1 (registered):
  - lo = pp_0 + (pp_1<<18) + (pp_2<<36), 81 bits
  - hi = pp_3 + (pp_4<<18) + (pp_5<<36), 81 bits
  - Registered together with v1 and tag1.
- Stage 2 (registered): prod = lo + (hi<<27), truncated to OUT_W.
  - No truncation occurs for legal inputs; the max product is (2^54-1)^2 < 2^108.
  - Registered together with out_valid and out_tag.
- Latency: exactly 2 clk cycles from an accepted input (in_valid & in_ready) to out_valid, when no stall occurs.
- Throughput: one operation per cycle while out_ready=1.
- Stall:
  - stall = out_valid & ~out_ready.
  - On stall, both stages hold all registers, including valids.
  - in_ready = ~stall (combinational from out_valid/out_ready).
- Bubble collapse: not required. A bubble in stage 1 still waits behind a stalled output.
- Input not accepted (in_valid=0 or in_ready=0): stage-1 valid loads 0 on an enabled cycle. Data registers may load don't-care values.
- Simultaneous in_valid and out_ready with out_valid=1: the output retires, the pipeline advances, and the new input enters in the same cycle.
- Output stability: while out_valid=1 and out_ready=0, prod and out_tag must not change.
- Reset:
  - rst_n low clears v1, out_valid, prod, out_tag and the stage-1 data to 0 immediately, independent of clk.
  - Any operation in flight when reset asserts mid-operation is dropped; no partial result appears after release.
  - First acceptance is possible on the first clk edge after rst_n deasserts.
- in_ready: is 1 during and after reset, because out_valid=0.
- Arithmetic: unsigned only; no overflow flag. All partial-product inputs are treated as zero-extended.

Test Plan:
- Reset values: hold rst_n=0 for 3 cycles -> out_valid=0, prod=0, out_tag=0, in_ready=1. Then send one op (a=1, b=1: pp_0=1, rest 0, tag=3) -> out_valid=1 exactly 2 cycles later with prod=1, out_tag=3.
- Top weight: partials for a=2^53, b=2^53 (pp_5=2^43, others 0) -> prod=2^106. Also a=b=2^54-1 with all six partials from the model -> prod=0xFFFFFFFFFFFFF80000000000001.
- Streaming: 64 back-to-back random (a,b) ops with out_ready=1 -> one result per cycle, 2-cycle latency, each prod equals a*b, tags in order.
- Backpressure: out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 after the first output, prod/out_tag held stable, no op lost or duplicated. Releasing out_ready -> results resume in order.
- Simultaneous accept/retire: out_valid=1, out_ready=1, in_valid=1 every cycle -> no bubble inserted and no stall asserted.
- Mid-flight reset: assert rst_n=0 asynchronously one cycle after accepting an op -> out_valid goes 0 without waiting for a clk edge. After release, no stale result appears.
